// File: rtl/reg_file_swap.sv
// ---------------------------------------------------------------------------
// reg_file_swap
//
// Purpose:
//   A parametrised register file with 2**AW entries of W bits each.
//   - Two independent combinational read ports, A and B.
//   - One write port, shared by two users:
//       * external writes, taken only while the swap sequencer is idle;
//       * a 3-state swap sequencer that exchanges core[rd_addrA] and
//         core[rd_addrB].
//   - The write address is regDst when regDst is non-zero, and wr_addr
//     otherwise.
//
// Optional feature (macro REG_FILE_BYPASS_EN):
//   When the macro is defined, a read port whose address matches the write
//   committing at the next edge shows that write's data combinationally.
//   When the macro is undefined, reads always return the array contents.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   wr_en      in   1   external write enable
//   wr_addr    in   AW  default write address
//   regDst     in   AW  destination override (used when non-zero)
//   dat_in     in   W   external write data
//   rd_addrA   in   AW  read port A address, and swap operand A
//   rd_addrB   in   AW  read port B address, and swap operand B
//   swap_req   in   1   request to swap core[rd_addrA] and core[rd_addrB]
//   datA_out   out  W   read data, port A
//   datB_out   out  W   read data, port B
//   swap_busy  out  1   high while the swap sequencer is not idle
//   swap_done  out  1   pulses for the cycle of the second swap write
//   wr_drop    out  1   pulses when an external write is discarded
// ---------------------------------------------------------------------------
module reg_file_swap #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] regDst,
  input  logic [W-1:0]  dat_in,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  input  logic          swap_req,
  output logic [W-1:0]  datA_out,
  output logic [W-1:0]  datB_out,
  output logic          swap_busy,
  output logic          swap_done,
  output logic          wr_drop
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_A = 2'd1,
    S_WR_B = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_core [DEPTH];
  logic [W-1:0]  r_tmp_a;
  logic [W-1:0]  r_tmp_b;
  logic [AW-1:0] r_sa;
  logic [AW-1:0] r_sb;

  logic [AW-1:0] w_ea;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;

  assign w_ea = (regDst != '0) ? regDst : wr_addr;

  // Only one commit per cycle can happen on the write port. It carries the
  // external write in IDLE, tmpB into sA in WR_A, and tmpA into sB in WR_B.
  // NOTE: every signal driven in an always_comb gets a default first, so an
  // unlisted branch can never infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = w_ea;
    w_wdata     = dat_in;
    case (r_state)
      S_IDLE: begin
        if (swap_req) begin
          w_state_nxt = S_WR_A;
        end else if (wr_en) begin
          w_we = 1'b1;
        end
      end
      S_WR_A: begin
        w_we        = 1'b1;
        w_waddr     = r_sa;
        w_wdata     = r_tmp_b;
        w_state_nxt = S_WR_B;
      end
      S_WR_B: begin
        w_we        = 1'b1;
        w_waddr     = r_sb;
        w_wdata     = r_tmp_a;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // No write is considered pending while reset is held. This keeps the
    // bypass path from showing data that will never commit.
    if (reset) begin
      w_we = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every register samples values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmp_a <= '0;
      r_tmp_b <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      // NOTE: the storage array is cleared on reset on purpose. Every
      // register must read 0 immediately, which rules out an
      // unreset RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_core[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && swap_req) begin
        r_tmp_a <= r_core[rd_addrA];
        r_tmp_b <= r_core[rd_addrB];
        r_sa    <= rd_addrA;
        r_sb    <= rd_addrB;
      end
      if (w_we) begin
        r_core[w_waddr] <= w_wdata;
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign datA_out = (w_we && (w_waddr == rd_addrA)) ? w_wdata : r_core[rd_addrA];
  assign datB_out = (w_we && (w_waddr == rd_addrB)) ? w_wdata : r_core[rd_addrB];
`else
  assign datA_out = r_core[rd_addrA];
  assign datB_out = r_core[rd_addrB];
`endif

  assign swap_busy = (r_state != S_IDLE);
  assign swap_done = (r_state == S_WR_B);
  // An external write is lost in two cases: it arrives during a swap, or it
  // arrives together with a swap request that takes the port.
  assign wr_drop   = wr_en && !reset && ((r_state != S_IDLE) || swap_req);

endmodule

// File: tb/tb_reg_file_swap.sv
// ---------------------------------------------------------------------------
// tb_reg_file_swap
//
// Self-checking bench for reg_file_swap (W=8, AW=2).
//
// The reference model holds the register contents as a plain array and an
// accepted swap as a queue of two pending writes. One write is retired per
// clock. From that model the bench derives the expected value of every
// output on every falling edge. Directed vectors carry hand-computed literal
// expectations, which also pin the model.
// ---------------------------------------------------------------------------
module tb_reg_file_swap;

  localparam int W  = 8;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] regDst;
  logic [W-1:0]  dat_in;
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic          swap_req;
  logic [W-1:0]  datA_out;
  logic [W-1:0]  datB_out;
  logic          swap_busy;
  logic          swap_done;
  logic          wr_drop;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_swap #(.W(W), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .regDst   (regDst),
    .dat_in   (dat_in),
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .swap_req (swap_req),
    .datA_out (datA_out),
    .datB_out (datB_out),
    .swap_busy(swap_busy),
    .swap_done(swap_done),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic [W-1:0] m_mem [4];
  wr_t          m_pend [$];

  function automatic logic [AW-1:0] eff_addr();
    return (regDst != 0) ? regDst : wr_addr;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
    if (!reset) begin
      if (m_pend.size() != 0) begin
        if (m_pend[0].addr == a) v = m_pend[0].data;
      end else if (wr_en && !swap_req && eff_addr() == a) begin
        v = dat_in;
      end
    end
`endif
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      m_pend.delete();
    end else if (m_pend.size() != 0) begin
      m_mem[m_pend[0].addr] = m_pend[0].data;
      void'(m_pend.pop_front());
    end else if (swap_req) begin
      // Read both operands before either write is queued, so a same-address
      // swap writes the original value back.
      m_pend.push_back('{addr: rd_addrA, data: m_mem[rd_addrB]});
      m_pend.push_back('{addr: rd_addrB, data: m_mem[rd_addrA]});
    end else if (wr_en) begin
      m_mem[eff_addr()] = dat_in;
    end
  end

  // The compare process runs on every falling edge, away from the edge
  // that updates state.
  always @(negedge clk) begin
    check("cyc_datA", datA_out, m_read(rd_addrA));
    check("cyc_datB", datB_out, m_read(rd_addrB));
    check("cyc_busy", swap_busy, m_pend.size() != 0);
    check("cyc_done", swap_done, !reset && m_pend.size() == 1);
    check("cyc_drop", wr_drop, !reset && wr_en && (m_pend.size() != 0 || swap_req));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    regDst  = '0;
    dat_in  = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    regDst   = '0;
    dat_in   = '0;
    rd_addrA = '0;
    rd_addrB = '0;
    swap_req = 1'b0;
    #12;
    reset = 1'b0;
    tick();
    check("rst_datA", datA_out, 8'h00);
    check("rst_busy", swap_busy, 1'b0);

    // Writes, then reads on independent ports.
    do_write(2'd1, 8'h5A);
    do_write(2'd2, 8'hC3);
    rd_addrA = 2'd1;
    rd_addrB = 2'd2;
    #1;
    check("rd_A_5A", datA_out, 8'h5A);
    check("rd_B_C3", datB_out, 8'hC3);

    // regDst overrides wr_addr.
    wr_en = 1'b1; wr_addr = 2'd1; regDst = 2'd3; dat_in = 8'h7E;
    tick();
    wr_en = 1'b0; regDst = '0;
    rd_addrA = 2'd3; rd_addrB = 2'd1;
    #1;
    check("regdst_3", datA_out, 8'h7E);
    check("regdst_1", datB_out, 8'h5A);

    // Swap core[0]=0x11 with core[3]=0x22. The operands change and swap_req
    // stays high during WR_A; both are ignored.
    do_write(2'd0, 8'h11);
    do_write(2'd3, 8'h22);
    rd_addrA = 2'd0; rd_addrB = 2'd3; swap_req = 1'b1;
    #1;
    check("swp_busy0", swap_busy, 1'b0);
    tick();
    rd_addrA = 2'd1; rd_addrB = 2'd2;
    #1;
    check("swp_busy1", swap_busy, 1'b1);
    check("swp_done1", swap_done, 1'b0);
    tick();
    swap_req = 1'b0;
    #1;
    check("swp_busy2", swap_busy, 1'b1);
    check("swp_done2", swap_done, 1'b1);
    tick();
    check("swp_busy3", swap_busy, 1'b0);
    check("swp_done3", swap_done, 1'b0);
    rd_addrA = 2'd0; rd_addrB = 2'd3;
    #1;
    check("swp_0", datA_out, 8'h22);
    check("swp_3", datB_out, 8'h11);

    // An external write during WR_A is dropped.
    rd_addrA = 2'd1; rd_addrB = 2'd2; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; dat_in = 8'hEE;
    #1;
    check("wra_drop", wr_drop, 1'b1);
    tick();
    wr_en = 1'b0;
    tick();
    check("wra_1", datA_out, 8'hC3);
    check("wra_2", datB_out, 8'h5A);

    // swap_req together with wr_en in IDLE: the swap wins.
    rd_addrA = 2'd0; rd_addrB = 2'd3; swap_req = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd2; dat_in = 8'hAB;
    #1;
    check("idl_drop", wr_drop, 1'b1);
    tick();
    swap_req = 1'b0; wr_en = 1'b0;
    tick();
    tick();
    check("idl_0", datA_out, 8'h11);
    check("idl_3", datB_out, 8'h22);
    rd_addrA = 2'd2;
    #1;
    check("idl_2", datA_out, 8'h5A);

    // Same-operand swap leaves the value unchanged.
    do_write(2'd1, 8'h44);
    rd_addrA = 2'd1; rd_addrB = 2'd1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    check("same_done", swap_done, 1'b1);
    tick();
    check("same_val", datA_out, 8'h44);
    check("same_done0", swap_done, 1'b0);

    // Reset in WR_A aborts the swap and clears everything at once.
    rd_addrA = 2'd0; rd_addrB = 2'd3; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mrst_busy", swap_busy, 1'b0);
    check("mrst_done", swap_done, 1'b0);
    check("mrst_A", datA_out, 8'h00);
    check("mrst_B", datB_out, 8'h00);
    #2;
    reset = 1'b0;
    tick();
    check("mrst_done_after", swap_done, 1'b0);
    for (int a = 0; a < 4; a++) begin
      rd_addrA = a[AW-1:0];
      rd_addrB = 2'(3 - a);
      #1;
      check("mrst_rdA", datA_out, 8'h00);
      check("mrst_rdB", datB_out, 8'h00);
    end

    // Same-cycle visibility of a write, with or without bypass.
    rd_addrA = 2'd2;
    wr_en = 1'b1; wr_addr = 2'd2; dat_in = 8'h99;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_same", datA_out, 8'h99);
`else
    check("byp_same", datA_out, 8'h00);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("byp_after", datA_out, 8'h99);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
